// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM encoding,
// CSR addresses, interrupt cause codes and ExcInfo/mstatus/mie bit positions.
`timescale 1ns/1ps
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SET_MEPC    = 3'd1,
    SET_MCAUSE  = 3'd2,
    SET_MSTATUS = 3'd3,
    MRET        = 3'd4
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [6:0] CAUSE_MSI = 7'd3;
  localparam logic [6:0] CAUSE_MTI = 7'd7;
  localparam logic [6:0] CAUSE_MEI = 7'd11;

  localparam int EXC_CH_W      = 16;
  localparam int EXC_VALID_BIT = 15;
  localparam int EXC_MRET_BIT  = 13;
  localparam int EXC_CAUSE_W   = 7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

endpackage

// File: rtl/trap_ctrl_if.sv
// Event-selection bundle between the trap FSM (master) and the priority
// arbiter (slave). int_pending and int_mask are both ordered {MEI, MTI, MSI}.
`timescale 1ns/1ps
interface trap_ctrl_if #(parameter int NSTAGE = 4);
  logic [NSTAGE*16-1:0] exc_info;
  logic [2:0]           int_pending;
  logic [2:0]           int_mask;
  logic                 global_ie;
  logic                 any_exc;
  logic                 sel_exc;
  logic                 sel_int;
  logic                 sel_mret;
  logic [6:0]           sel_cause;

  modport master (output exc_info, int_pending, int_mask, global_ie,
                  input  any_exc, sel_exc, sel_int, sel_mret, sel_cause);
  modport slave  (input  exc_info, int_pending, int_mask, global_ie,
                  output any_exc, sel_exc, sel_int, sel_mret, sel_cause);
endinterface

// File: rtl/trap_arbiter.sv
// Combinational event selector: exception (MSB channel wins) > enabled
// interrupt (MEI > MSI > MTI) > mret. At most one sel_* output is high.
`timescale 1ns/1ps
module trap_arbiter
  import trap_pkg::*;
#(
  parameter int NSTAGE = 4
) (
  trap_ctrl_if.slave arb
);

  logic       w_exc;
  logic       w_mret;
  logic [6:0] w_exc_cause;
  logic [6:0] w_int_cause;
  logic [2:0] w_int_act;
  logic       w_int;

  // Later iterations overwrite earlier ones, so the highest channel wins.
  always_comb begin
    w_exc       = 1'b0;
    w_mret      = 1'b0;
    w_exc_cause = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (arb.exc_info[i*EXC_CH_W + EXC_VALID_BIT]) begin
        w_exc       = 1'b1;
        w_exc_cause = arb.exc_info[i*EXC_CH_W +: EXC_CAUSE_W];
      end
      if (arb.exc_info[i*EXC_CH_W + EXC_MRET_BIT]) begin
        w_mret = 1'b1;
      end
    end
  end

  assign w_int_act = arb.int_pending & arb.int_mask & {3{arb.global_ie}};
  assign w_int     = |w_int_act;

  always_comb begin
    w_int_cause = '0;
    if (w_int_act[2])      w_int_cause = CAUSE_MEI;
    else if (w_int_act[0]) w_int_cause = CAUSE_MSI;
    else if (w_int_act[1]) w_int_cause = CAUSE_MTI;
  end

  assign arb.any_exc   = w_exc;
  assign arb.sel_exc   = w_exc;
  assign arb.sel_int   = !w_exc && w_int;
  assign arb.sel_mret  = !w_exc && !w_int && w_mret;
  assign arb.sel_cause = w_exc ? w_exc_cause : w_int_cause;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: accepts one exception/interrupt/mret in IDLE,
// then writes mepc, mcause, mstatus one per cycle and redirects the fetch PC.
// Optional vectored interrupt targets are enabled by TRAP_CTRL_VECTORED_EN.
`timescale 1ns/1ps
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int              XLEN    = 64,
  parameter int              NSTAGE  = 4,
  parameter logic [XLEN-1:0] PC_INIT = '0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [XLEN-1:0]      InstAddrIn,
  input  logic [NSTAGE*16-1:0] ExcInfoIn,
  input  logic [2:0]           IntPendingIn,
  input  logic [XLEN-1:0]      CsrMstatusIn,
  input  logic [XLEN-1:0]      CsrMtvecIn,
  input  logic [XLEN-1:0]      CsrMepcIn,
  input  logic [XLEN-1:0]      CsrMieIn,
  output logic                 CsrWriteEnableOut,
  output logic [11:0]          CsrWriteAddrOut,
  output logic [XLEN-1:0]      CsrWriteDataOut,
  output logic                 HoldFlagOut,
  output logic                 HoldFlagEndOut,
  output logic [XLEN-1:0]      JumpAddrOut,
  output logic                 ExcStopRegfileOut
);

  trap_ctrl_if #(.NSTAGE(NSTAGE)) u_arb_if ();

  assign u_arb_if.exc_info    = ExcInfoIn;
  assign u_arb_if.int_pending = IntPendingIn;
  assign u_arb_if.int_mask    = {CsrMieIn[MIE_MEIE], CsrMieIn[MIE_MTIE], CsrMieIn[MIE_MSIE]};
  assign u_arb_if.global_ie   = CsrMstatusIn[MSTATUS_MIE];

  trap_arbiter #(.NSTAGE(NSTAGE)) u_arbiter (.arb(u_arb_if.slave));

  trap_state_e     r_state;
  trap_state_e     w_next;
  logic [XLEN-1:0] r_pc;
  logic [6:0]      r_cause;
  logic            r_intflag;
  logic            w_trap;
  logic            w_accept;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_trap_target;
  logic [XLEN-1:0] w_mst_trap;
  logic [XLEN-1:0] w_mst_mret;

  assign w_trap   = u_arb_if.sel_exc | u_arb_if.sel_int;
  assign w_accept = (r_state == IDLE) && (w_trap | u_arb_if.sel_mret);
  assign w_base   = {CsrMtvecIn[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
  assign w_trap_target = (CsrMtvecIn[1:0] == 2'b01 && r_intflag)
                       ? w_base + {{(XLEN-9){1'b0}}, r_cause, 2'b00}
                       : w_base;
`else
  assign w_trap_target = w_base;
`endif

  always_comb begin
    w_mst_trap                         = CsrMstatusIn;
    w_mst_trap[MSTATUS_MPIE]           = CsrMstatusIn[MSTATUS_MIE];
    w_mst_trap[MSTATUS_MIE]            = 1'b0;
    w_mst_trap[MSTATUS_MPP_LO +: 2]    = 2'b11;
    w_mst_mret                         = CsrMstatusIn;
    w_mst_mret[MSTATUS_MIE]            = CsrMstatusIn[MSTATUS_MPIE];
    w_mst_mret[MSTATUS_MPIE]           = 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_cause   <= '0;
      r_intflag <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_trap) begin
        r_pc      <= InstAddrIn;
        r_cause   <= u_arb_if.sel_cause;
        r_intflag <= u_arb_if.sel_int;
      end
    end
  end

  // Rst gates the IDLE-state combinational outputs so reset forces them idle at once.
  always_comb begin
    w_next            = r_state;
    CsrWriteEnableOut = 1'b0;
    CsrWriteAddrOut   = '0;
    CsrWriteDataOut   = '0;
    HoldFlagOut       = 1'b1;
    HoldFlagEndOut    = 1'b0;
    JumpAddrOut       = PC_INIT;
    case (r_state)
      IDLE: begin
        HoldFlagOut = w_accept && !Rst;
        if (w_trap)                     w_next = SET_MEPC;
        else if (u_arb_if.sel_mret)     w_next = MRET;
      end
      SET_MEPC: begin
        CsrWriteEnableOut = 1'b1;
        CsrWriteAddrOut   = CSR_MEPC;
        CsrWriteDataOut   = r_pc;
        w_next            = SET_MCAUSE;
      end
      SET_MCAUSE: begin
        CsrWriteEnableOut = 1'b1;
        CsrWriteAddrOut   = CSR_MCAUSE;
        CsrWriteDataOut   = {r_intflag, {(XLEN-8){1'b0}}, r_cause};
        w_next            = SET_MSTATUS;
      end
      SET_MSTATUS: begin
        CsrWriteEnableOut = 1'b1;
        CsrWriteAddrOut   = CSR_MSTATUS;
        CsrWriteDataOut   = w_mst_trap;
        HoldFlagEndOut    = 1'b1;
        JumpAddrOut       = w_trap_target;
        w_next            = IDLE;
      end
      MRET: begin
        CsrWriteEnableOut = 1'b1;
        CsrWriteAddrOut   = CSR_MSTATUS;
        CsrWriteDataOut   = w_mst_mret;
        HoldFlagEndOut    = 1'b1;
        JumpAddrOut       = CsrMepcIn;
        w_next            = IDLE;
      end
      default: begin
        HoldFlagOut = 1'b0;
        w_next      = IDLE;
      end
    endcase
  end

  assign ExcStopRegfileOut = u_arb_if.any_exc && !Rst;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a table of single-event vectors walked cycle by
// cycle, plus hand sequences for ignored events and reset mid-sequence.
`timescale 1ns/1ps
module tb_trap_ctrl;

  localparam int XLEN   = 64;
  localparam int NSTAGE = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [XLEN-1:0]   InstAddrIn;
  logic [63:0]       ExcInfoIn;
  logic [2:0]        IntPendingIn;
  logic [XLEN-1:0]   CsrMstatusIn, CsrMtvecIn, CsrMepcIn, CsrMieIn;
  logic              CsrWriteEnableOut;
  logic [11:0]       CsrWriteAddrOut;
  logic [XLEN-1:0]   CsrWriteDataOut;
  logic              HoldFlagOut, HoldFlagEndOut, ExcStopRegfileOut;
  logic [XLEN-1:0]   JumpAddrOut;

  always #5 Clk = ~Clk;

  trap_ctrl #(.XLEN(XLEN), .NSTAGE(NSTAGE), .PC_INIT('0)) dut (
    .Clk(Clk), .Rst(Rst), .InstAddrIn(InstAddrIn), .ExcInfoIn(ExcInfoIn),
    .IntPendingIn(IntPendingIn), .CsrMstatusIn(CsrMstatusIn), .CsrMtvecIn(CsrMtvecIn),
    .CsrMepcIn(CsrMepcIn), .CsrMieIn(CsrMieIn), .CsrWriteEnableOut(CsrWriteEnableOut),
    .CsrWriteAddrOut(CsrWriteAddrOut), .CsrWriteDataOut(CsrWriteDataOut),
    .HoldFlagOut(HoldFlagOut), .HoldFlagEndOut(HoldFlagEndOut),
    .JumpAddrOut(JumpAddrOut), .ExcStopRegfileOut(ExcStopRegfileOut)
  );

  // kind: 0 = nothing accepted, 1 = trap sequence, 2 = mret
  typedef struct {
    logic [63:0] exc;
    logic [2:0]  pend;
    logic [63:0] mstatus, mie, mtvec, mepc, pc;
    int          kind;
    logic        exp_stop;
    logic [63:0] exp_mcause, exp_mstatus, exp_jump;
  } vec_t;

`ifdef TRAP_CTRL_VECTORED_EN
  localparam logic [63:0] MTI_JUMP = 64'h101C;
  localparam logic [63:0] MEI_JUMP = 64'h502C;
`else
  localparam logic [63:0] MTI_JUMP = 64'h1000;
  localparam logic [63:0] MEI_JUMP = 64'h5000;
`endif

  vec_t vecs[11];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [11:0] addr,
                         input logic [63:0] data, input logic hold, input logic hend,
                         input logic [63:0] jump);
    chk({tag, "_we"},   64'(CsrWriteEnableOut), 64'(we));
    chk({tag, "_addr"}, 64'(CsrWriteAddrOut),   64'(addr));
    chk({tag, "_data"}, CsrWriteDataOut,        data);
    chk({tag, "_hold"}, 64'(HoldFlagOut),       64'(hold));
    chk({tag, "_hend"}, 64'(HoldFlagEndOut),    64'(hend));
    chk({tag, "_jump"}, JumpAddrOut,            jump);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    ExcInfoIn    = v.exc;
    IntPendingIn = v.pend;
    CsrMstatusIn = v.mstatus;
    CsrMieIn     = v.mie;
    CsrMtvecIn   = v.mtvec;
    CsrMepcIn    = v.mepc;
    InstAddrIn   = v.pc;
  endtask

  task automatic clear_events();
    ExcInfoIn    = '0;
    IntPendingIn = '0;
  endtask

  function automatic vec_t mk(input logic [63:0] exc, input logic [2:0] pend,
                              input logic [63:0] mstatus, input logic [63:0] mie,
                              input logic [63:0] mtvec, input logic [63:0] mepc,
                              input logic [63:0] pc, input int kind, input logic stop,
                              input logic [63:0] mcause, input logic [63:0] mst,
                              input logic [63:0] jump);
    vec_t v;
    v.exc = exc; v.pend = pend; v.mstatus = mstatus; v.mie = mie; v.mtvec = mtvec;
    v.mepc = mepc; v.pc = pc; v.kind = kind; v.exp_stop = stop;
    v.exp_mcause = mcause; v.exp_mstatus = mst; v.exp_jump = jump;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    drive(v);
    #1;
    chk({t, "_T_hold"}, 64'(HoldFlagOut), 64'(v.kind != 0));
    chk({t, "_T_stop"}, 64'(ExcStopRegfileOut), 64'(v.exp_stop));
    chk({t, "_T_we"},   64'(CsrWriteEnableOut), 64'd0);
    chk({t, "_T_jump"}, JumpAddrOut, 64'd0);
    tick();
    clear_events();
    #1;
    if (v.kind == 1) begin
      chk_out({t, "_mepc"}, 1'b1, 12'h341, v.pc, 1'b1, 1'b0, 64'd0);
      tick();
      chk_out({t, "_mcause"}, 1'b1, 12'h342, v.exp_mcause, 1'b1, 1'b0, 64'd0);
      tick();
      chk_out({t, "_mstatus"}, 1'b1, 12'h300, v.exp_mstatus, 1'b1, 1'b1, v.exp_jump);
      tick();
    end else if (v.kind == 2) begin
      chk_out({t, "_mret"}, 1'b1, 12'h300, v.exp_mstatus, 1'b1, 1'b1, v.exp_jump);
      tick();
    end
    chk_out({t, "_idle"}, 1'b0, 12'h0, 64'd0, 1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(64'h8002_0000_0000_0000, 3'b000, 64'h8,    64'h0,   64'h1000, 64'h0,    64'h8000_0100, 1, 1'b1, 64'h2,                   64'h1880, 64'h1000);
    vecs[1]  = mk(64'h0,                   3'b110, 64'h8,    64'h880, 64'h2000, 64'h0,    64'h400,       1, 1'b0, 64'h8000_0000_0000_000B, 64'h1880, 64'h2000);
    vecs[2]  = mk(64'h0,                   3'b010, 64'h8,    64'h80,  64'h1001, 64'h0,    64'h500,       1, 1'b0, 64'h8000_0000_0000_0007, 64'h1880, MTI_JUMP);
    vecs[3]  = mk(64'h0000_8006_2000_8004, 3'b111, 64'h8,    64'h888, 64'h3000, 64'h0,    64'h600,       1, 1'b1, 64'h6,                   64'h1880, 64'h3000);
    vecs[4]  = mk(64'h0000_0000_0000_2000, 3'b000, 64'h80,   64'h0,   64'h1000, 64'h2000, 64'h0,         2, 1'b0, 64'h0,                   64'h88,   64'h2000);
    vecs[5]  = mk(64'h0,                   3'b111, 64'h0,    64'h888, 64'h1000, 64'h0,    64'h0,         0, 1'b0, 64'h0,                   64'h0,    64'h0);
    vecs[6]  = mk(64'h0,                   3'b011, 64'hA,    64'h88,  64'h4000, 64'h0,    64'h700,       1, 1'b0, 64'h8000_0000_0000_0003, 64'h1882, 64'h4000);
    vecs[7]  = mk(64'h2000_0000_0000_0000, 3'b100, 64'h8,    64'h800, 64'h5001, 64'h0,    64'h800,       1, 1'b0, 64'h8000_0000_0000_000B, 64'h1880, MEI_JUMP);
    vecs[8]  = mk(64'h0,                   3'b111, 64'h8,    64'h777, 64'h1000, 64'h0,    64'h0,         0, 1'b0, 64'h0,                   64'h0,    64'h0);
    vecs[9]  = mk(64'h0000_0000_0000_800D, 3'b000, 64'h1888, 64'h0,   64'h1001, 64'h0,    64'h900,       1, 1'b1, 64'hD,                   64'h1880, 64'h1000);
    vecs[10] = mk(64'h0000_2000_0000_0000, 3'b000, 64'h8,    64'h0,   64'h1000, 64'hABC0, 64'h0,         2, 1'b0, 64'h0,                   64'h80,   64'hABC0);

    // Reset: outputs idle even with an exception presented.
    Rst = 1'b1;
    drive(vecs[0]);
    #2;
    chk_out("reset", 1'b0, 12'h0, 64'd0, 1'b0, 1'b0, 64'd0);
    chk("reset_stop", 64'(ExcStopRegfileOut), 64'd0);
    clear_events();
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Events during a sequence are ignored; pending interrupt retaken in IDLE.
    drive(mk(64'h8002_0000_0000_0000, 3'b000, 64'h8, 64'h800, 64'h6000, 64'h0, 64'h100, 1, 1'b1, 64'h2, 64'h1880, 64'h6000));
    #1;
    chk("ign_T_hold", 64'(HoldFlagOut), 64'd1);
    tick();
    ExcInfoIn    = 64'h8009_0000_0000_2000;
    IntPendingIn = 3'b100;
    InstAddrIn   = 64'h999;
    #1;
    chk_out("ign_mepc", 1'b1, 12'h341, 64'h100, 1'b1, 1'b0, 64'd0);
    tick();
    chk_out("ign_mcause", 1'b1, 12'h342, 64'h2, 1'b1, 1'b0, 64'd0);
    tick();
    ExcInfoIn = '0;
    #1;
    chk_out("ign_mstatus", 1'b1, 12'h300, 64'h1880, 1'b1, 1'b1, 64'h6000);
    tick();
    chk("reeval_hold", 64'(HoldFlagOut), 64'd1);
    chk("reeval_we", 64'(CsrWriteEnableOut), 64'd0);
    tick();
    IntPendingIn = '0;
    #1;
    chk_out("reeval_mepc", 1'b1, 12'h341, 64'h999, 1'b1, 1'b0, 64'd0);
    tick();
    chk_out("reeval_mcause", 1'b1, 12'h342, 64'h8000_0000_0000_000B, 1'b1, 1'b0, 64'd0);
    tick();
    chk_out("reeval_mstatus", 1'b1, 12'h300, 64'h1880, 1'b1, 1'b1, 64'h6000);
    tick();
    chk_out("reeval_idle", 1'b0, 12'h0, 64'd0, 1'b0, 1'b0, 64'd0);

    // Reset pulsed in SET_MCAUSE: no mstatus write or redirect afterwards.
    drive(vecs[0]);
    #1;
    tick();
    clear_events();
    #1;
    tick();
    chk("rst_mid_addr", 64'(CsrWriteAddrOut), 64'h342);
    Rst = 1'b1;
    #1;
    chk_out("rst_mid_async", 1'b0, 12'h0, 64'd0, 1'b0, 1'b0, 64'd0);
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_out($sformatf("rst_after%0d", i), 1'b0, 12'h0, 64'd0, 1'b0, 1'b0, 64'd0);
      tick();
    end
    drive(vecs[4]);
    #1;
    chk("rst_idle_hold", 64'(HoldFlagOut), 64'd1);
    tick();
    clear_events();
    #1;
    chk_out("rst_idle_mret", 1'b1, 12'h300, 64'h88, 1'b1, 1'b1, 64'h2000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath and CSR width.
REQ-002 SHALL have parameter NSTAGE, default 4, meaning the number of pipeline exception channels.
REQ-003 SHALL have parameter PC_INIT, default 0, meaning the idle value of JumpAddrOut.
REQ-004 SHALL have port Clk, input, 1 bit: the only clock.
REQ-005 SHALL have port Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port InstAddrIn, input, XLEN bits: PC of the oldest uncommitted instruction.
REQ-007 SHALL have port ExcInfoIn, input, NSTAGE*16 bits: per-channel info with bit15 = exception valid, bit13 = mret, [6:0] = cause; the MSB channel is highest priority.
REQ-008 SHALL have port IntPendingIn, input, 3 bits: {MEIP, MTIP, MSIP}.
REQ-009 SHALL have ports CsrMstatusIn, CsrMtvecIn, CsrMepcIn and CsrMieIn, each input, XLEN bits: current CSR values.
REQ-010 SHALL have port CsrWriteEnableOut, output, 1 bit: CSR write strobe.
REQ-011 SHALL have port CsrWriteAddrOut, output, 12 bits: CSR write address.
REQ-012 SHALL have port CsrWriteDataOut, output, XLEN bits: CSR write data.
REQ-013 SHALL have port HoldFlagOut, output, 1 bit: pipeline stall.
REQ-014 SHALL have port HoldFlagEndOut, output, 1 bit: one-cycle redirect strobe.
REQ-015 SHALL have port JumpAddrOut, output, XLEN bits: redirect target, valid while HoldFlagEndOut is high.
REQ-016 SHALL have port ExcStopRegfileOut, output, 1 bit: suppresses regfile writeback while any exception is valid.

Function
REQ-017 The FSM SHALL have states IDLE, SET_MEPC, SET_MCAUSE, SET_MSTATUS and MRET; IDLE SHALL be the only state that accepts events.
REQ-018 In IDLE the priority SHALL be: a valid exception on any channel first, then an enabled interrupt, then mret on any channel; a lower-priority event that occurs at the same time SHALL be dropped.
REQ-019 An interrupt SHALL be enabled when mstatus[3] is 1 and (IntPendingIn & {mie[11], mie[7], mie[3]}) is nonzero; the priority among interrupts SHALL be MEI (11), then MSI (3), then MTI (7).
REQ-020 On acceptance (cycle T) the block SHALL latch the PC, the cause and an interrupt flag, and go to SET_MEPC.
REQ-021 The states SHALL write one CSR per cycle: T+1 writes mepc (0x341) with the latched PC; T+2 writes mcause (0x342) with {intflag, zeros, cause[6:0]}; T+3 writes mstatus (0x300) with MPIE<=MIE, MIE<=0, MPP<=2'b11.
REQ-022 In SET_MSTATUS the block SHALL pulse HoldFlagEndOut for one cycle and drive JumpAddrOut with the trap target, then return to IDLE.
REQ-023 On mret the block SHALL go to MRET; at T+1 it SHALL write mstatus with MIE<=MPIE and MPIE<=1, pulse HoldFlagEndOut, drive JumpAddrOut = mepc, and return to IDLE.
REQ-024 HoldFlagOut SHALL be combinational in IDLE when an event is accepted, and high in every state other than IDLE.
REQ-025 Events that arrive in any state other than IDLE SHALL be ignored; pending interrupts SHALL be re-evaluated on return to IDLE.
REQ-026 Outside the write states the outputs SHALL be: CsrWriteEnableOut = 0, address = 0, data = 0, and JumpAddrOut = PC_INIT.
REQ-027 The base trap target SHALL be {mtvec[XLEN-1:2], 2'b00}.

Reset
REQ-028 Asserting Rst SHALL immediately force the state to IDLE, clear all latched registers and force all outputs to the idle values.
REQ-029 If Rst is asserted mid-sequence, the remaining CSR writes and the redirect SHALL NOT be issued.

Configuration
REQ-030 If TRAP_CTRL_VECTORED_EN is defined, mtvec[1:0] is 2'b01 and the trap is an interrupt, the target SHALL be base + 4*cause; exceptions SHALL always use the base.
REQ-031 If TRAP_CTRL_VECTORED_EN is not defined, mtvec[1:0] SHALL be ignored and all traps SHALL use the base.

Structure
REQ-032 A shared package trap_pkg SHALL hold the state encoding, the CSR addresses (0x300, 0x341, 0x342), the interrupt cause codes and the ExcInfo bit positions.
REQ-033 The combinational priority selector SHALL be one sub-module, trap_arbiter, parameterised by NSTAGE.

Verification
REQ-034 Stimulus: channel 3 bit15 = 1 with cause 0x02, PC 0x8000_0100 -> required response: writes mepc = 0x8000_0100, mcause = 0x2, then mstatus with MIE = 0, and a redirect to the mtvec base at T+3.
REQ-035 Stimulus: MTIP and MEIP both pending, MIE = 1, mie = 0x880 -> required response: mcause = 0x8000_0000_0000_000B.
REQ-036 Stimulus: vectored macro defined, mtvec = 0x1001, MTIP interrupt -> required response: JumpAddrOut = 0x101C; with the macro undefined -> required response: JumpAddrOut = 0x1000.
REQ-037 Stimulus: exception and mret in the same cycle -> required response: the exception sequence only; stimulus: mret alone with mepc = 0x2000 -> required response: JumpAddrOut = 0x2000 at T+1 and MIE restored.
REQ-038 Stimulus: Rst pulsed in SET_MCAUSE -> required response: no mstatus write, no HoldFlagEndOut, state IDLE.
